fc_score_streamer: RTL and testbench

FC_SCORE_STREAMER -- requirements
Module: fc_score_streamer

---
 rtl/fc_score_streamer_pkg.sv | 22 ++
 rtl/fc_score_streamer_if.sv | 27 ++
 rtl/fc_score_streamer_score_saturate.sv | 29 ++
 rtl/fc_score_streamer.sv | 109 ++++++++++
 tb/tb_fc_score_streamer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fc_score_streamer_pkg.sv
// Shared types and constants for the FC score streamer: FSM encoding and
// saturation limits for signed score words.
package fc_score_streamer_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int INDEX_W = 5;

    // Largest and smallest representable values of a w-bit signed score.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

endpackage

// File: rtl/fc_score_streamer_if.sv
// Accumulator-in / score-pair-out handshake bundle for the FC score streamer.
// master = producer/consumer around the block, slave = the streamer itself.
interface fc_score_streamer_if #(
    parameter int ACC_WIDTH  = 24,
    parameter int DATA_WIDTH = 16
);
    logic                         in_valid;
    logic signed [ACC_WIDTH-1:0]  in_data;
    logic                         in_last;
    logic                         in_ready;
    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] out_a;
    logic signed [DATA_WIDTH-1:0] out_b;
    logic [4:0]                   out_index;
    logic                         out_ready;
    logic                         frame_done;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_index, frame_done
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_a, out_b, out_index, frame_done
    );
endinterface

// File: rtl/fc_score_streamer_score_saturate.sv
// Converts one accumulator to a score: arithmetic shift right, then clamp.
// Purely combinational; no handshake.
module score_saturate
    import fc_score_streamer_pkg::*;
#(
    parameter int ACC_WIDTH  = 24,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_SHIFT = 4
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] score
);
    localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(sat_min(DATA_WIDTH));

    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH-1:0] clamped;

    always_comb begin
        shifted = acc >>> FRAC_SHIFT;
        clamped = shifted;
        if (shifted > MAX_V) begin
            clamped = MAX_V;
        end else if (shifted < MIN_V) begin
            clamped = MIN_V;
        end
        score = DATA_WIDTH'(clamped);
    end
endmodule

// File: rtl/fc_score_streamer.sv
// Buffers one frame of class accumulators as saturated scores, then streams
// them out as (even, odd) channel pairs; input is held off while streaming.
module fc_score_streamer
    import fc_score_streamer_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ACC_WIDTH      = 24,
    parameter int FRAC_SHIFT     = 4,
    parameter int OUTPUT_CHANNEL = 10
) (
    input logic              clk,
    input logic              rst,
    fc_score_streamer_if.slave bus
);
    localparam int NPAIR = OUTPUT_CHANNEL / 2;
    localparam logic signed [DATA_WIDTH-1:0] PAD = DATA_WIDTH'(sat_min(DATA_WIDTH));

    state_t state, state_nxt;
    logic [4:0] wr_cnt;
    logic [3:0] rd_cnt;
    logic signed [DATA_WIDTH-1:0] buffer [OUTPUT_CHANNEL];
    logic signed [DATA_WIDTH-1:0] conv_score;

    logic in_fire, out_fire, fill_end, last_pair;

    score_saturate #(
        .ACC_WIDTH (ACC_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_SHIFT(FRAC_SHIFT)
    ) u_sat (
        .acc  (bus.in_data),
        .score(conv_score)
    );

    assign in_fire   = bus.in_valid && bus.in_ready;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign fill_end  = in_fire && (bus.in_last || (wr_cnt == 5'(OUTPUT_CHANNEL - 1)));
    assign last_pair = (rd_cnt == 4'(NPAIR - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL:   if (fill_end) state_nxt = ST_STREAM;
            ST_STREAM: if (out_fire && last_pair) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_FILL;
            default:   state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (in_fire) begin
                wr_cnt <= fill_end ? 5'd0 : wr_cnt + 5'd1;
            end
            if (out_fire) begin
                rd_cnt <= last_pair ? 4'd0 : rd_cnt + 4'd1;
            end
        end
    end

    // An early in_last pads every later slot in the same edge, so stale
    // entries from the previous frame can never leak into the stream.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int i = 0; i < OUTPUT_CHANNEL; i++) begin
                if (5'(i) == wr_cnt) begin
                    buffer[i] <= conv_score;
                end else if (bus.in_last && (5'(i) > wr_cnt)) begin
                    buffer[i] <= PAD;
                end
            end
        end
    end

    always_comb begin
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.frame_done = 1'b0;
        bus.out_a      = '0;
        bus.out_b      = '0;
        bus.out_index  = '0;
        case (state)
            ST_FILL: bus.in_ready = 1'b1;
            ST_STREAM: begin
                bus.out_valid = 1'b1;
                bus.out_index = {rd_cnt, 1'b0};
                for (int k = 0; k < NPAIR; k++) begin
                    if (rd_cnt == 4'(k)) begin
                        bus.out_a = buffer[2*k];
                        bus.out_b = buffer[2*k+1];
                    end
                end
            end
            ST_DONE: bus.frame_done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_fc_score_streamer.sv
// Directed bench for fc_score_streamer with a pair scoreboard fed by a frame model.
module tb_fc_score_streamer;
    logic clk;
    logic rst;

    fc_score_streamer_if #(.ACC_WIDTH(24), .DATA_WIDTH(16)) bus ();

    fc_score_streamer #(
        .DATA_WIDTH(16), .ACC_WIDTH(24), .FRAC_SHIFT(4), .OUTPUT_CHANNEL(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  idx;
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    pair_t sb[$];
    logic [15:0] mbuf [10];
    int mcnt = 0;
    int compared = 0;
    int mismatched = 0;
    int done_cnt = 0;
    int exp_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] conv(input logic signed [23:0] d);
        int v;
        v = int'(d) >>> 4;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    // Frame model: builds the 10-entry score frame and queues its 5 pairs.
    task automatic model_push(input logic signed [23:0] d, input logic l);
        mbuf[mcnt] = conv(d);
        mcnt++;
        if (l || mcnt == 10) begin
            for (int i = mcnt; i < 10; i++) mbuf[i] = 16'h8000;
            for (int k = 0; k < 5; k++) sb.push_back({5'(2*k), mbuf[2*k], mbuf[2*k+1]});
            mcnt = 0;
            exp_done++;
        end
    endtask

    // Called and returns at posedge+1; the word is accepted at the edge before return.
    task automatic send(input logic signed [23:0] d, input logic l);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        model_push(d, l);
    endtask

    task automatic drain(input bit rnd, output int cycles);
        int n;
        n = 0;
        while (done_cnt < exp_done && n < 400) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        cycles = n;
        chk("drain_done", done_cnt, exp_done);
        chk("after_done_pulse", {31'b0, bus.frame_done}, 32'd0);
        chk("after_done_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("sb_empty_after_frame", sb.size(), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid === 1'b1) begin
                chk("pair_expected", {31'b0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    chk("out_index", {27'b0, bus.out_index}, {27'b0, sb[0].idx});
                    chk("out_a", {16'b0, bus.out_a}, {16'b0, sb[0].a});
                    chk("out_b", {16'b0, bus.out_b}, {16'b0, sb[0].b});
                    if (bus.out_ready === 1'b1) void'(sb.pop_front());
                end
            end
            if (bus.frame_done === 1'b1) begin
                done_cnt++;
                chk("done_all_pairs_taken", sb.size(), 32'd0);
                chk("done_out_valid", {31'b0, bus.out_valid}, 32'd0);
                chk("done_in_ready", {31'b0, bus.in_ready}, 32'd0);
            end
        end
    end

    initial begin
        int cyc;
        int done_before;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_frame_done", {31'b0, bus.frame_done}, 32'd0);
        chk("rst_out_a", {16'b0, bus.out_a}, 32'd0);
        chk("rst_out_b", {16'b0, bus.out_b}, 32'd0);
        chk("rst_out_index", {27'b0, bus.out_index}, 32'd0);

        // Basic frame with out_ready high: pairs on consecutive cycles
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) send(24'(16 * c), c == 9);
        chk("first_valid_latency", {31'b0, bus.out_valid}, 32'd1);
        drain(1'b0, cyc);
        chk("basic_stream_cycles", cyc, 32'd6);

        // Saturation
        send(24'sh400000, 1'b0);
        send(-24'sh400000, 1'b0);
        send(-24'sd17, 1'b0);
        for (int c = 3; c < 10; c++) send(24'(-100 * c), c == 9);
        drain(1'b0, cyc);

        // Short frame: 6 words, the rest pad to most-negative
        for (int c = 0; c < 6; c++) send(24'(1000 + 32 * c), c == 5);
        drain(1'b0, cyc);

        // Backpressure with random data and random out_ready
        bus.out_ready = 1'b0;
        for (int c = 0; c < 10; c++) send(24'($urandom), c == 9);
        drain(1'b1, cyc);

        // Overlong frame: words 11/12 start the next frame
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) send(24'(48 * c + 5), 1'b0);
        chk("overlong_in_ready_drop", {31'b0, bus.in_ready}, 32'd0);
        send(24'(7777), 1'b0);
        send(-24'sd7777, 1'b0);
        for (int c = 2; c < 10; c++) send(24'(-16 * c), c == 9);
        drain(1'b0, cyc);

        // Reset on the 3rd STREAM cycle
        for (int c = 0; c < 10; c++) send(24'(160 * c), c == 9);
        done_before = done_cnt;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_done--;
        chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_out_a", {16'b0, bus.out_a}, 32'd0);
        chk("midrst_out_b", {16'b0, bus.out_b}, 32'd0);
        chk("midrst_out_index", {27'b0, bus.out_index}, 32'd0);
        chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt, done_before);
        for (int c = 0; c < 10; c++) send(24'(-320 * c + 3), c == 9);
        drain(1'b0, cyc);
        chk("postrst_stream_cycles", cyc, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
